// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: opcodes, FSM states,
// instruction classes, immediate/write-back selectors and trap codes.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CLS_R, CLS_IALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_AUIPC, CLS_ILLEGAL
  } cls_e;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_J    = 3'd3,
    IMM_U    = 3'd4,
    IMM_NONE = 3'd7
  } imm_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_IMEM    = 2'd2;
  localparam logic [1:0] ERR_DMEM    = 2'd3;

  function automatic wb_e wb_sel_of(cls_e cls);
    case (cls)
      CLS_LOAD: return WB_LOAD;
      CLS_JAL:  return WB_PC4;
      default:  return WB_ALU;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Handshake and datapath-control bundle between the control unit (master)
// and the datapath/memories (slave).
interface multicycle_ctrl_if;
  logic [31:0] inst_code;
  logic        imem_req;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        branch_taken;
  logic        ir_we;
  logic [2:0]  imm_sel;
  logic        alu_src_imm;
  logic        rf_we;
  logic        pc_we;
  logic        pc_sel;
  logic [1:0]  wb_sel;
  logic        trap;
  logic [1:0]  err_code;
  logic [31:0] instret;

  modport master (
    input  inst_code, imem_ack, dmem_ack, branch_taken,
    output imem_req, dmem_req, dmem_we, ir_we, imm_sel, alu_src_imm,
           rf_we, pc_we, pc_sel, wb_sel, trap, err_code, instret
  );

  modport slave (
    output inst_code, imem_ack, dmem_ack, branch_taken,
    input  imem_req, dmem_req, dmem_we, ir_we, imm_sel, alu_src_imm,
           rf_we, pc_we, pc_sel, wb_sel, trap, err_code, instret
  );
endinterface

// File: rtl/multicycle_ctrl_opcode_decode.sv
// Combinational opcode classifier: instruction class plus the immediate format
// the datapath must use for the rest of the instruction.
module opcode_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_e       cls,
  output imm_e       imm_sel
);

  always_comb begin
    cls     = CLS_ILLEGAL;
    imm_sel = IMM_NONE;
    case (opcode)
      OP_R:      begin cls = CLS_R;      imm_sel = IMM_NONE; end
      OP_IALU:   begin cls = CLS_IALU;   imm_sel = IMM_I;    end
      OP_LOAD:   begin cls = CLS_LOAD;   imm_sel = IMM_I;    end
      OP_STORE:  begin cls = CLS_STORE;  imm_sel = IMM_S;    end
      OP_BRANCH: begin cls = CLS_BRANCH; imm_sel = IMM_B;    end
      OP_JAL:    begin cls = CLS_JAL;    imm_sel = IMM_J;    end
      OP_AUIPC:  begin cls = CLS_AUIPC;  imm_sel = IMM_U;    end
      default:   begin cls = CLS_ILLEGAL; imm_sel = IMM_NONE; end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with bounded
// memory waits, sticky trap reporting and a retired-instruction counter.
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  state_e     state;
  state_e     nxt;
  logic [3:0] wait_cnt;
  logic [6:0] ir_op;
  cls_e       cls;
  imm_e       dec_imm;
  logic       wb_pc_we;
  logic       jal_pc_sel;
  logic       timed_out;
  logic       unused_inst_bits;

  opcode_decode u_decode (
    .opcode  (ir_op),
    .cls     (cls),
    .imm_sel (dec_imm)
  );

  assign timed_out = (wait_cnt == TO_LAST);
  // Operand and function fields are consumed by the datapath, not here.
  assign unused_inst_bits = ^bus.inst_code[31:7];

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ack)   nxt = S_DECODE;
        else if (timed_out) nxt = S_TRAP;
      end
      S_DECODE: nxt = (cls == CLS_ILLEGAL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (cls)
          CLS_BRANCH:          nxt = S_FETCH;
          CLS_LOAD, CLS_STORE: nxt = S_MEM;
          default:             nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ack)   nxt = (cls == CLS_STORE) ? S_FETCH : S_WB;
        else if (timed_out) nxt = S_TRAP;
      end
      S_WB:     nxt = S_FETCH;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_IDLE;
    endcase
  end

  // Ack- and branch-dependent strobes cannot be known a cycle early, so they
  // are combined with the registered WB terms here; rst masks them.
  assign bus.ir_we  = !rst && (state == S_FETCH) && bus.imem_ack;
  assign bus.pc_we  = wb_pc_we ||
                      (!rst && (((state == S_EXEC) && (cls == CLS_BRANCH)) ||
                                ((state == S_MEM) && (cls == CLS_STORE) && bus.dmem_ack)));
  assign bus.pc_sel = jal_pc_sel ||
                      (!rst && (state == S_EXEC) && (cls == CLS_BRANCH) && bus.branch_taken);

  always_ff @(posedge clk) begin
    if ((state == S_FETCH) && bus.imem_ack) ir_op <= bus.inst_code[6:0];
    if (rst) begin
      state           <= S_IDLE;
      wait_cnt        <= '0;
      bus.instret     <= '0;
      bus.trap        <= 1'b0;
      bus.err_code    <= ERR_NONE;
      bus.imem_req    <= 1'b0;
      bus.dmem_req    <= 1'b0;
      bus.dmem_we     <= 1'b0;
      bus.alu_src_imm <= 1'b0;
      bus.rf_we       <= 1'b0;
      bus.wb_sel      <= WB_ALU;
      bus.imm_sel     <= IMM_I;
      wb_pc_we        <= 1'b0;
      jal_pc_sel      <= 1'b0;
    end else begin
      state <= nxt;
      if ((nxt != state) && ((nxt == S_FETCH) || (nxt == S_MEM)))
        wait_cnt <= '0;
      else if ((state == S_FETCH) || (state == S_MEM))
        wait_cnt <= wait_cnt + 4'd1;
      if (bus.pc_we) bus.instret <= bus.instret + 32'd1;

      // Outputs are registered against the state being entered.
      bus.imem_req    <= (nxt == S_FETCH);
      bus.dmem_req    <= (nxt == S_MEM);
      bus.dmem_we     <= (nxt == S_MEM) && (cls == CLS_STORE);
      bus.alu_src_imm <= (nxt == S_EXEC) && !((cls == CLS_R) || (cls == CLS_BRANCH));
      bus.rf_we       <= (nxt == S_WB);
      wb_pc_we        <= (nxt == S_WB);
      jal_pc_sel      <= (nxt == S_WB) && (cls == CLS_JAL);
      bus.wb_sel      <= (nxt == S_WB) ? wb_sel_of(cls) : WB_ALU;
      bus.imm_sel     <= ((nxt == S_EXEC) || (nxt == S_MEM) || (nxt == S_WB)) ? dec_imm : IMM_I;
      bus.trap        <= (nxt == S_TRAP);
      if ((nxt == S_TRAP) && (state != S_TRAP))
        bus.err_code <= (state == S_FETCH) ? ERR_IMEM :
                        (state == S_MEM)   ? ERR_DMEM : ERR_ILLEGAL;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction cycle traces are built
// from the instruction-level rules and compared against the DUT every cycle.
module tb_multicycle_ctrl;

  localparam int TO = 6;

  localparam int PH_RST   = 0;
  localparam int PH_IDLE  = 1;
  localparam int PH_FETCH = 2;
  localparam int PH_DEC   = 3;
  localparam int PH_EXEC  = 4;
  localparam int PH_MEM   = 5;
  localparam int PH_WB    = 6;
  localparam int PH_TRAP  = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iack;
    logic        dack;
    logic        taken;
    logic [31:0] inst;
    logic        chk;
    int          ph;
    logic [15:0] ctl;
    logic [31:0] iret;
  } rec_t;

  rec_t        q[$];
  logic [31:0] m_instret = '0;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          n_imem_req, n_rf_we, n_pc_we, n_dmem_we;
  logic [31:0] first_iret;
  logic        first_seen;
  logic        last_trap;
  logic [1:0]  last_err;

  function automatic string ph_name(int p);
    case (p)
      PH_RST:   return "reset";
      PH_IDLE:  return "idle";
      PH_FETCH: return "fetch";
      PH_DEC:   return "decode";
      PH_EXEC:  return "exec";
      PH_MEM:   return "mem";
      PH_WB:    return "wb";
      default:  return "trap";
    endcase
  endfunction

  // {imem_req,dmem_req,dmem_we,ir_we,imm_sel[3],alu_src_imm,rf_we,pc_we,pc_sel,wb_sel[2],trap,err[2]}
  function automatic logic [15:0] ctl_of(logic ireq, logic dreq, logic dwe, logic irwe,
                                         logic [2:0] imm, logic alu, logic rfwe, logic pcwe,
                                         logic pcsel, logic [1:0] wb, logic trp, logic [1:0] err);
    return {ireq, dreq, dwe, irwe, imm, alu, rfwe, pcwe, pcsel, wb, trp, err};
  endfunction

  function automatic logic [2:0] imm_of(logic [6:0] op);
    case (op)
      7'h33:   return 3'd7;
      7'h13:   return 3'd0;
      7'h03:   return 3'd0;
      7'h23:   return 3'd1;
      7'h63:   return 3'd2;
      7'h6F:   return 3'd3;
      7'h17:   return 3'd4;
      default: return 3'd7;
    endcase
  endfunction

  task automatic push(input logic r, input logic iack, input logic dack, input logic taken,
                      input logic [31:0] inst, input logic chk, input int ph, input logic [15:0] ctl);
    rec_t e;
    e.rst = r; e.iack = iack; e.dack = dack; e.taken = taken; e.inst = inst;
    e.chk = chk; e.ph = ph; e.ctl = ctl; e.iret = m_instret;
    q.push_back(e);
  endtask

  task automatic push_reset();
    push(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, PH_RST, '0);
    m_instret = '0;
    push(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, PH_IDLE, '0);
  endtask

  task automatic push_trap(input logic [1:0] err, input logic [31:0] inst);
    for (int n = 0; n < 4; n++)
      push(1'b0, 1'b1, 1'b1, 1'b1, inst, 1'b1, PH_TRAP,
           ctl_of('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b1, err));
  endtask

  // One instruction: di/dd are wait cycles before imem/dmem ack (>= TO means never);
  // rst_mem >= 0 pulses rst in that MEM cycle instead.
  task automatic gen_instr(input logic [31:0] inst, input int di, input int dd,
                           input logic taken, input int rst_mem);
    logic [6:0] op;
    logic [2:0] imm;
    logic       is_r, is_br, is_ld, is_st, is_jal, legal, ack;
    logic [1:0] wb;
    op     = inst[6:0];
    imm    = imm_of(op);
    is_r   = (op == 7'h33);
    is_br  = (op == 7'h63);
    is_ld  = (op == 7'h03);
    is_st  = (op == 7'h23);
    is_jal = (op == 7'h6F);
    legal  = is_r || is_br || is_ld || is_st || is_jal || (op == 7'h13) || (op == 7'h17);

    for (int k = 0; k < TO; k++) begin
      ack = (k == di);
      push(1'b0, ack, 1'b0, taken, inst, 1'b1, PH_FETCH,
           ctl_of(1'b1, '0, '0, ack, '0, '0, '0, '0, '0, '0, '0, '0));
      if (ack) break;
    end
    if (di >= TO) begin push_trap(2'd2, inst); return; end

    push(1'b0, 1'b0, 1'b0, taken, inst, 1'b1, PH_DEC, '0);
    if (!legal) begin push_trap(2'd1, inst); return; end

    push(1'b0, 1'b0, 1'b0, taken, inst, 1'b1, PH_EXEC,
         ctl_of('0, '0, '0, '0, imm, !(is_r || is_br), '0, is_br, is_br && taken, '0, '0, '0));
    if (is_br) begin m_instret++; return; end

    if (is_ld || is_st) begin
      for (int k = 0; k < TO; k++) begin
        if (k == rst_mem) begin
          push(1'b1, 1'b0, 1'b1, taken, inst, 1'b0, PH_RST, '0);
          m_instret = '0;
          push(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, PH_IDLE, '0);
          return;
        end
        ack = (k == dd);
        push(1'b0, 1'b0, ack, taken, inst, 1'b1, PH_MEM,
             ctl_of('0, 1'b1, is_st, '0, imm, '0, '0, is_st && ack, '0, '0, '0, '0));
        if (ack) break;
      end
      if (dd >= TO) begin push_trap(2'd3, inst); return; end
      if (is_st) begin m_instret++; return; end
    end

    wb = is_ld ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
    push(1'b0, 1'b0, 1'b0, taken, inst, 1'b1, PH_WB,
         ctl_of('0, '0, '0, '0, imm, '0, 1'b1, 1'b1, is_jal, wb, '0, '0));
    m_instret++;
  endtask

  task automatic run_all();
    rec_t        e;
    logic [15:0] act;
    n_imem_req = 0; n_rf_we = 0; n_pc_we = 0; n_dmem_we = 0;
    first_seen = 1'b0;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clk);
      #1;
      rst              = e.rst;
      bus.imem_ack     = e.iack;
      bus.dmem_ack     = e.dack;
      bus.branch_taken = e.taken;
      bus.inst_code    = e.inst;
      @(negedge clk);
      cyc++;
      if (e.chk) begin
        act = ctl_of(bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.imm_sel,
                     bus.alu_src_imm, bus.rf_we, bus.pc_we, bus.pc_sel, bus.wb_sel,
                     bus.trap, bus.err_code);
        checks++;
        if (act !== e.ctl || bus.instret !== e.iret) begin
          errors++;
          $display("FAIL cycle %0d %s: got ctl=%h instret=%0d, want ctl=%h instret=%0d",
                   cyc, ph_name(e.ph), act, bus.instret, e.ctl, e.iret);
        end
        if (!first_seen) begin first_iret = bus.instret; first_seen = 1'b1; end
        n_imem_req += int'(bus.imem_req);
        n_rf_we    += int'(bus.rf_we);
        n_pc_we    += int'(bus.pc_we);
        n_dmem_we  += int'(bus.dmem_we);
        last_trap  = bus.trap;
        last_err   = bus.err_code;
      end
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.branch_taken = 1'b0; bus.inst_code = '0;

    push_reset(); run_all();

    gen_instr(32'h00500093, 2, 0, 1'b0, -1); run_all();
    lit("addi_fetch_cycles", n_imem_req, 3);
    lit("addi_rf_we", n_rf_we, 1);
    lit("addi_pc_we", n_pc_we, 1);

    gen_instr(32'h00208463, 0, 0, 1'b1, -1); run_all();
    lit("instret_after_addi", first_iret, 1);
    lit("beq_rf_we", n_rf_we, 0);
    lit("beq_pc_we", n_pc_we, 1);

    gen_instr(32'h00208463, 0, 0, 1'b0, -1); run_all();

    gen_instr(32'h0020A223, 1, 3, 1'b0, -1); run_all();
    lit("instret_before_sw", first_iret, 3);
    lit("sw_dmem_we_cycles", n_dmem_we, 4);
    lit("sw_pc_we", n_pc_we, 1);

    gen_instr(32'h0000A103, 0, 1, 1'b0, -1);
    gen_instr(32'h008000EF, 0, 0, 1'b0, -1);
    gen_instr(32'h00001117, 0, 0, 1'b0, -1);
    gen_instr(32'h002081B3, 0, 0, 1'b1, -1);
    run_all();
    lit("mix_pc_we", n_pc_we, 4);
    lit("mix_rf_we", n_rf_we, 4);

    gen_instr(32'h0000007F, 0, 0, 1'b0, -1); run_all();
    lit("illegal_trap", last_trap, 1);
    lit("illegal_err", last_err, 1);
    lit("illegal_pc_we", n_pc_we, 0);

    push_reset();
    gen_instr(32'h00500093, TO, 0, 1'b0, -1); run_all();
    lit("imem_timeout_fetch_cycles", n_imem_req, 6);
    lit("imem_timeout_err", last_err, 2);

    push_reset();
    gen_instr(32'h00500093, TO - 1, 0, 1'b0, -1); run_all();
    lit("late_ack_fetch_cycles", n_imem_req, 6);
    lit("late_ack_pc_we", n_pc_we, 1);

    gen_instr(32'h0000A103, 0, TO, 1'b0, -1); run_all();
    lit("dmem_timeout_err", last_err, 3);

    push_reset();
    gen_instr(32'h0000A103, 0, 5, 1'b0, 2);
    gen_instr(32'h00500093, 0, 0, 1'b0, -1);
    run_all();
    lit("after_mid_mem_rst_pc_we", n_pc_we, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
